// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone arbiter: one transfer per grant, round-robin on ties,
// with a watchdog that force-acks a silent slave and pulses err_o.
module wb_arbiter_2to1 #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  // instruction master
  input  logic [31:0] i_addr_i,
  input  logic [31:0] i_data_i,
  input  logic        i_we_i,
  input  logic [3:0]  i_sel_i,
  input  logic        i_stb_i,
  input  logic        i_cyc_i,
  output logic [31:0] i_data_o,
  output logic        i_ack_o,
  // data master
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_stb_i,
  input  logic        d_cyc_i,
  output logic [31:0] d_data_o,
  output logic        d_ack_o,
  // shared slave
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  // status
  output logic        err_o,
  output logic [1:0]  grant_o
);

  // State encoding doubles as the grant_o code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_t             state_q, state_d;
  logic               last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Master-indexed views: index 0 = instruction, 1 = data.
  logic [31:0] m_addr [2];
  logic [31:0] m_wdat [2];
  logic        m_we   [2];
  logic [3:0]  m_sel  [2];
  logic        m_stb  [2];
  logic        m_cyc  [2];
  logic [31:0] m_rdat [2];
  logic        m_ack  [2];
  logic [1:0]  req;

  logic granted;
  logic owner;
  logic owner_cyc;
  logic out_en;
  logic timeout_hit;

  assign m_addr[0] = i_addr_i;
  assign m_wdat[0] = i_data_i;
  assign m_we[0]   = i_we_i;
  assign m_sel[0]  = i_sel_i;
  assign m_stb[0]  = i_stb_i;
  assign m_cyc[0]  = i_cyc_i;
  assign m_addr[1] = d_addr_i;
  assign m_wdat[1] = d_data_i;
  assign m_we[1]   = d_we_i;
  assign m_sel[1]  = d_sel_i;
  assign m_stb[1]  = d_stb_i;
  assign m_cyc[1]  = d_cyc_i;

  assign granted   = (state_q == GNT_I) || (state_q == GNT_D);
  assign owner     = (state_q == GNT_D) ? OWNER_D : OWNER_I;
  assign owner_cyc = m_cyc[owner];
  assign out_en    = granted && !rst;

  // A dropped cyc is an abort and outranks the watchdog; a real ack outranks it too.
  assign timeout_hit = granted && owner_cyc && !s_ack_i && (cnt_q == TIMEOUT_CNT);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      logic is_owner;
      assign req[gi]    = m_cyc[gi] & m_stb[gi];
      assign is_owner   = out_en && (owner == 1'(gi));
      assign m_ack[gi]  = is_owner && owner_cyc && (s_ack_i || timeout_hit);
      assign m_rdat[gi] = (is_owner && !timeout_hit) ? s_data_i : 32'd0;
    end
  endgenerate

  assign i_data_o = m_rdat[0];
  assign i_ack_o  = m_ack[0];
  assign d_data_o = m_rdat[1];
  assign d_ack_o  = m_ack[1];
  assign err_o    = timeout_hit && !rst;
  assign grant_o  = out_en ? state_q : IDLE;

  always_comb begin
    s_addr_o = 32'd0;
    s_data_o = 32'd0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'd0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    if (out_en) begin
      s_addr_o = m_addr[owner];
      s_data_o = m_wdat[owner];
      s_we_o   = m_we[owner];
      s_sel_o  = m_sel[owner];
      s_stb_o  = m_stb[owner];
      s_cyc_o  = m_cyc[owner];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req[0] && req[1]) begin
          state_d = (last_owner_q == OWNER_I) ? GNT_D : GNT_I;
        end else if (req[1]) begin
          state_d = GNT_D;
        end else if (req[0]) begin
          state_d = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (!owner_cyc || s_ack_i || timeout_hit) begin
          state_d      = IDLE;
          last_owner_d = owner;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_I;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1 with a scoreboard of expected master acks.
module tb_wb_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr_i, i_data_i, d_addr_i, d_data_i;
  logic        i_we_i, i_stb_i, i_cyc_i, d_we_i, d_stb_i, d_cyc_i;
  logic [3:0]  i_sel_i, d_sel_i;
  logic [31:0] i_data_o, d_data_o;
  logic        i_ack_o, d_ack_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic        err_o;
  logic [1:0]  grant_o;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_we_i(i_we_i), .i_sel_i(i_sel_i),
    .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
    .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .err_o(err_o), .grant_o(grant_o)
  );

  typedef struct packed {
    logic [1:0]  who;   // 01 instruction, 10 data
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_grant(input string name, input logic [1:0] g);
    check(name, {30'd0, grant_o}, {30'd0, g});
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_s_addr"}, s_addr_o, 32'd0);
    check({name, "_s_data"}, s_data_o, 32'd0);
    check({name, "_ctrl"}, {20'd0, s_we_o, s_sel_o, s_stb_o, s_cyc_o, i_ack_o, d_ack_o, err_o, grant_o}, 32'd0);
    check({name, "_i_data"}, i_data_o, 32'd0);
    check({name, "_d_data"}, d_data_o, 32'd0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic idle_masters();
    i_addr_i = 32'd0; i_data_i = 32'd0; i_we_i = 1'b0; i_sel_i = 4'd0; i_stb_i = 1'b0; i_cyc_i = 1'b0;
    d_addr_i = 32'd0; d_data_i = 32'd0; d_we_i = 1'b0; d_sel_i = 4'd0; d_stb_i = 1'b0; d_cyc_i = 1'b0;
  endtask

  task automatic push(input logic [1:0] who, input logic [31:0] data, input logic err);
    exp_t e;
    e.who  = who;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack or error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (i_ack_o === 1'b1 || d_ack_o === 1'b1 || err_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_ack: actual i_ack=%b d_ack=%b err=%b required no response",
                 i_ack_o, d_ack_o, err_o);
      end else begin
        e = exp_q.pop_front();
        check("ack_owner", {30'd0, d_ack_o, i_ack_o}, {30'd0, e.who});
        check("ack_data", (e.who == 2'b01) ? i_data_o : d_data_o, e.data);
        check("ack_err", {31'd0, err_o}, {31'd0, e.err});
        check("nonowner_data", (e.who == 2'b01) ? d_data_o : i_data_o, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset with live inputs: outputs must still be forced low.
    rst = 1'b1;
    idle_masters();
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_addr_i = 32'h0000_1234;
    s_ack_i = 1'b1; s_data_i = 32'h0000_FFFF;
    next_cycle();
    at_sample(); check_all_zero("reset");
    next_cycle();
    idle_masters(); s_ack_i = 1'b0; s_data_i = 32'd0; rst = 1'b0;
    at_sample(); check_grant("post_reset_grant", 2'b00); check("post_reset_cyc", {31'd0, s_cyc_o}, 32'd0);
    next_cycle();

    // Single read from data master, slave acks in the 3rd granted cycle.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_addr_i = 32'h8000_0010; d_we_i = 1'b0; d_sel_i = 4'hF;
    at_sample(); check_grant("rd_req_cycle", 2'b00);
    next_cycle();
    at_sample(); check_grant("rd_grant", 2'b10); check("rd_s_addr", s_addr_o, 32'h8000_0010);
    check("rd_s_we", {31'd0, s_we_o}, 32'd0);
    next_cycle();
    at_sample(); check_grant("rd_wait", 2'b10);
    next_cycle();
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF; push(2'b10, 32'hDEAD_BEEF, 1'b0);
    at_sample();
    next_cycle();
    s_ack_i = 1'b0; s_data_i = 32'd0; idle_masters();
    at_sample(); check_grant("rd_done", 2'b00);
    next_cycle();

    // Reset again so the tie starts from the reset priority.
    rst = 1'b1;
    at_sample(); check_all_zero("reset2");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // Tie: both held continuously, slave acks every cycle (ignored while idle).
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_addr_i = 32'h0000_0100;
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_addr_i = 32'h0000_0200;
    s_ack_i = 1'b1;
    at_sample(); check_grant("tie_req_cycle", 2'b00);
    next_cycle();
    for (int k = 0; k < 7; k++) begin
      logic [1:0] who;
      who = ((k / 2) % 2 == 0) ? 2'b10 : 2'b01;
      if (k % 2 == 0) begin
        s_data_i = 32'hA000_0000 + 32'(k);
        push(who, s_data_i, 1'b0);
        at_sample();
        check_grant("tie_grant", who);
        check("tie_s_addr", s_addr_o, (who == 2'b10) ? 32'h0000_0200 : 32'h0000_0100);
      end else begin
        at_sample();
        check_grant("tie_idle_gap", 2'b00);
      end
      next_cycle();
    end
    idle_masters(); s_ack_i = 1'b0; s_data_i = 32'd0;
    at_sample(); check_grant("tie_end", 2'b00);
    next_cycle();

    // Write passthrough from data master; instruction presents noise without cyc.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0011;
    d_data_i = 32'h0000_1234; d_addr_i = 32'h0000_0040;
    i_addr_i = 32'hDEAD_0000; i_data_i = 32'h0000_CAFE; i_sel_i = 4'hF; i_stb_i = 1'b1;
    at_sample();
    next_cycle();
    at_sample(); check_grant("wr_grant", 2'b10);
    check("wr_s_we", {31'd0, s_we_o}, 32'd1);
    check("wr_s_sel", {28'd0, s_sel_o}, 32'h3);
    check("wr_s_data", s_data_o, 32'h0000_1234);
    check("wr_s_addr", s_addr_o, 32'h0000_0040);
    next_cycle();
    s_ack_i = 1'b1; s_data_i = 32'h55AA_55AA; push(2'b10, 32'h55AA_55AA, 1'b0);
    at_sample(); check("wr_s_data_ack", s_data_o, 32'h0000_1234);
    next_cycle();
    idle_masters(); s_ack_i = 1'b0; s_data_i = 32'd0;
    at_sample(); check_grant("wr_done", 2'b00);
    next_cycle();

    // Watchdog: slave silent, forced ack with zero data in the 5th granted cycle.
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_addr_i = 32'h0000_0300;
    s_data_i = 32'hFFFF_FFFF;
    at_sample();
    next_cycle();
    for (int n = 1; n <= 5; n++) begin
      if (n == 5) push(2'b01, 32'd0, 1'b1);
      at_sample(); check_grant("to_grant", 2'b01);
      next_cycle();
    end
    idle_masters(); s_data_i = 32'd0;
    at_sample(); check_grant("to_after", 2'b00); check("to_err_after", {31'd0, err_o}, 32'd0);
    next_cycle();

    // Slave acks exactly in the timeout cycle: a normal ack, no error.
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_addr_i = 32'h0000_0304;
    at_sample();
    next_cycle();
    for (int n = 1; n <= 5; n++) begin
      if (n == 5) begin
        s_ack_i = 1'b1; s_data_i = 32'h1111_2222;
        push(2'b01, 32'h1111_2222, 1'b0);
      end
      at_sample(); check_grant("bnd_grant", 2'b01);
      next_cycle();
    end
    idle_masters(); s_ack_i = 1'b0; s_data_i = 32'd0;
    at_sample(); check_grant("bnd_after", 2'b00);
    next_cycle();

    // Abort after 2 granted cycles, with a late slave ack in the same cycle.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_addr_i = 32'h0000_0500;
    at_sample();
    next_cycle();
    at_sample(); check_grant("ab_grant1", 2'b10);
    next_cycle();
    at_sample(); check_grant("ab_grant2", 2'b10);
    next_cycle();
    d_cyc_i = 1'b0; d_stb_i = 1'b0; s_ack_i = 1'b1; s_data_i = 32'h7777_7777;
    at_sample(); check_grant("ab_drop_grant", 2'b10);
    check("ab_drop_cyc", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    next_cycle();
    s_ack_i = 1'b0; s_data_i = 32'd0;
    at_sample(); check_grant("ab_after", 2'b00);
    next_cycle();

    // Reset mid-grant, then a tie must again go to data first.
    d_cyc_i = 1'b1; d_stb_i = 1'b1; d_addr_i = 32'h0000_0600;
    at_sample();
    next_cycle();
    at_sample(); check_grant("rm_grant", 2'b10);
    next_cycle();
    rst = 1'b1; s_ack_i = 1'b1; s_data_i = 32'h0000_0099;
    at_sample(); check_all_zero("rst_mid");
    next_cycle();
    at_sample(); check_all_zero("rst_mid2");
    next_cycle();
    rst = 1'b0; s_ack_i = 1'b0; s_data_i = 32'd0;
    i_cyc_i = 1'b1; i_stb_i = 1'b1; i_addr_i = 32'h0000_0700;
    at_sample(); check_grant("rm_idle", 2'b00); check("rm_idle_cyc", {31'd0, s_cyc_o}, 32'd0);
    next_cycle();
    s_ack_i = 1'b1; s_data_i = 32'hABCD_0001; push(2'b10, 32'hABCD_0001, 1'b0);
    at_sample(); check_grant("rm_tie_grant", 2'b10);
    next_cycle();
    idle_masters(); s_ack_i = 1'b0; s_data_i = 32'd0;
    at_sample();
    next_cycle();
    next_cycle();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
